mem_fill_responder: RTL and testbench
=====================================

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to first data beat (legal 2..7).
REQ-002 SHALL have parameter WORDS_LOG2, default 15, meaning log2 of backing-store depth in 16-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port fill_req  input  1  level request for one 16-byte line; held until fill_ack.
REQ-006 SHALL have port fill_addr  input  16  byte address of missed word; bits [3:0] ignored for base.
REQ-007 SHALL have port fill_ack  output  1  one-cycle pulse: request accepted this cycle.
REQ-008 SHALL have port wr_en  input  1  single-word store request, level, held until wr_ack.
REQ-009 SHALL have port wr_addr  input  16  byte address of store; bit 0 ignored.
REQ-010 SHALL have port wr_data  input  16  store data.
REQ-011 SHALL have port wr_ack  output  1  one-cycle pulse: store committed this cycle.
REQ-012 SHALL have port busy  output  1  high from cycle after fill_ack through last beat.
REQ-013 SHALL have port data_out  output  16  fill beat data, meaningful only with data_valid.
REQ-014 SHALL have port data_valid  output  1  high for exactly 8 consecutive cycles per fill.
REQ-015 SHALL have port data_addr  output  16  byte address of current beat: {base[15:4], beat, 1'b0}.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, BURST.
REQ-017 IDLE: wr_en high -> commit store, pulse wr_ack, stay IDLE; stores take priority over fills.
REQ-018 IDLE: fill_req high and wr_en low -> pulse fill_ack, latch base = fill_addr[15:4], load wait counter LATENCY-1, go WAIT.
REQ-019 WAIT: decrement 3-bit counter each cycle; at 1 go BURST with beat counter 0 (first beat exactly LATENCY cycles after fill_ack cycle).
REQ-020 BURST: drive data_valid, data_out = store[{base,beat}] (combinational read of current array), beat increments by 1; after beat 7 return IDLE, no idle gap required before next accept.
REQ-021 Beats SHALL be in order word 0..7, never critical-word-first.
REQ-022 wr_en and fill_req in WAIT/BURST SHALL be ignored (no ack) until IDLE; no store can alter a line mid-fill.
REQ-023 Store address index = wr_addr[WORDS_LOG2:1]; higher bits wrap (aliasing permitted).
REQ-024 fill_ack and wr_ack SHALL never be high in the same cycle.
REQ-025 data_out SHALL read 16'h0000 when data_valid low.

Reset
REQ-026 rst SHALL immediately force IDLE, counters 0, base 0; fill_ack, wr_ack, busy, data_valid low; data_out, data_addr 0.
REQ-027 Reset mid-WAIT/BURST SHALL abort the fill with no further beats; backing store contents SHALL NOT be cleared.
REQ-028 First request after rst deasserts SHALL be accepted in the first IDLE cycle.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (2 bits), BEATS_PER_LINE=8, LINE_OFFSET_BITS=4.
REQ-030 Backing store SHALL be one sub-module, mem_word_array (one write port, one async read port, no reset of contents).
REQ-031 Counters SHALL be 3-bit; no other sub-modules.

Verification
REQ-032 Store 16'hBEEF to 16'h0402, then fill_req addr 16'h040A -> wr_ack cycle 0, fill_ack cycle 1, data_valid cycles 5..12, beat 1 = 16'hBEEF, data_addr 16'h0400..16'h040E.
REQ-033 wr_en and fill_req asserted same IDLE cycle -> wr_ack first, fill_ack next cycle, fill returns new data.
REQ-034 wr_en asserted during BURST -> no wr_ack until cycle after last beat; burst data unchanged.
REQ-035 Back-to-back fills 16'h0000 and 16'hFFF0 held continuously -> second fill_ack in cycle after first's beat 7; data_addr ends 16'hFFFE.
REQ-036 rst pulsed during beat 3 -> data_valid, busy low immediately; previously stored words intact on next fill.
REQ-037 LATENCY=2 build -> first data_valid exactly 2 cycles after fill_ack.

Source files
------------

// File: rtl/mem_fill_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_fill_responder_pkg
//   Definitions shared by the memory fill responder and its backing store.
//   - fill_state_t     : 2-bit FSM state encoding (IDLE, WAIT, BURST)
//   - BEATS_PER_LINE   : 16-bit words returned per fill (one 16-byte line)
//   - LINE_OFFSET_BITS : byte-offset bits inside one line
//   - beat_byte_addr() : byte address of one beat within a line
// -----------------------------------------------------------------------------
package mem_fill_responder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      BURST = 2'b10
   } fill_state_t;

   localparam int BEATS_PER_LINE   = 8;
   localparam int LINE_OFFSET_BITS = 4;
   localparam int BEAT_W           = 3;
   localparam int BASE_W           = 16 - LINE_OFFSET_BITS;

   // Bit 0 is always zero: every beat is an aligned 16-bit word.
   function automatic logic [15:0] beat_byte_addr(input logic [BASE_W-1:0] base,
                                                  input logic [BEAT_W-1:0] beat);
      return {base, beat, 1'b0};
   endfunction

endpackage

// File: rtl/mem_fill_responder_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
//   Backing store for the fill responder: one synchronous write port and one
//   asynchronous (combinational) read port. Contents are never reset so that
//   stored data survives a reset of the control logic.
//   Ports:
//     clk   - write clock
//     we    - write enable, samples waddr/wdata on rising edge
//     waddr - write word index
//     wdata - write data
//     raddr - read word index
//     rdata - read data, combinational from the current array contents
// -----------------------------------------------------------------------------
module mem_word_array #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_fill_responder.sv
// -----------------------------------------------------------------------------
// mem_fill_responder
//   Answers cache line fills from a local word array. A fill request is
//   accepted in IDLE, waits LATENCY cycles, then streams the eight 16-bit
//   words of the addressed 16-byte line in ascending order. Single-word
//   stores are committed only in IDLE and win over a fill in the same cycle,
//   so a line can never change while it is being returned.
//   Parameters:
//     LATENCY    - cycles from fill_ack to first beat (2..7)
//     WORDS_LOG2 - log2 of store depth in 16-bit words (1..15)
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     fill_req/fill_addr  - level line request and byte address of the miss
//     fill_ack            - one-cycle acceptance pulse
//     wr_en/wr_addr/wr_data - level single-word store request
//     wr_ack              - one-cycle store-commit pulse
//     busy                - fill in progress (WAIT or BURST)
//     data_out/data_valid/data_addr - beat stream, zero when not valid
// -----------------------------------------------------------------------------
module mem_fill_responder
   import mem_fill_responder_pkg::*;
#(
   parameter int LATENCY    = 4,
   parameter int WORDS_LOG2 = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fill_req,
   input  logic [15:0] fill_addr,
   output logic        fill_ack,
   input  logic        wr_en,
   input  logic [15:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_ack,
   output logic        busy,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic [15:0] data_addr
);

   // The wait counter is loaded in the accept cycle and leaves WAIT when it
   // reads 1, which places beat 0 exactly LATENCY cycles after fill_ack.
   localparam logic [BEAT_W-1:0] WAIT_LOAD = BEAT_W'(LATENCY - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

   fill_state_t        state_q, state_d;
   logic [BEAT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [BASE_W-1:0]  base_q, base_d;
   logic               fill_ack_c;
   logic               wr_ack_c;

   logic [14:0]        wr_word;
   logic [14:0]        rd_word;
   logic [15:0]        rd_data;
   logic               unused_addr_bits;

   // Word indices; bits above WORDS_LOG2 are dropped, so addresses alias.
   assign wr_word = wr_addr[15:1];
   assign rd_word = {base_q, beat_q};

   // Byte offset bits are don't-care for both ports.
   assign unused_addr_bits = ^{fill_addr[LINE_OFFSET_BITS-1:0], wr_addr[0]};

   mem_word_array #(
      .ADDR_W (WORDS_LOG2),
      .DATA_W (16)
   ) u_store (
      .clk   (clk),
      .we    (wr_ack_c),
      .waddr (wr_word[WORDS_LOG2-1:0]),
      .wdata (wr_data),
      .raddr (rd_word[WORDS_LOG2-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         beat_q     <= '0;
         base_q     <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         beat_q     <= beat_d;
         base_q     <= base_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      beat_d     = beat_q;
      base_d     = base_q;
      fill_ack_c = 1'b0;
      wr_ack_c   = 1'b0;

      case (state_q)
         IDLE: begin
            // Acks are combinational from IDLE; rst masks them so nothing is
            // acknowledged or written while reset is held.
            if (!rst) begin
               if (wr_en) begin
                  wr_ack_c = 1'b1;
               end else if (fill_req) begin
                  fill_ack_c = 1'b1;
                  base_d     = fill_addr[15:LINE_OFFSET_BITS];
                  wait_cnt_d = WAIT_LOAD;
                  beat_d     = '0;
                  state_d    = WAIT;
               end
            end
         end

         WAIT: begin
            if (wait_cnt_q <= BEAT_W'(1)) begin
               wait_cnt_d = '0;
               beat_d     = '0;
               state_d    = BURST;
            end else begin
               wait_cnt_d = wait_cnt_q - BEAT_W'(1);
            end
         end

         BURST: begin
            // Return straight to IDLE so a held request is taken next cycle.
            if (beat_q == LAST_BEAT) begin
               beat_d  = '0;
               state_d = IDLE;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign fill_ack   = fill_ack_c;
   assign wr_ack     = wr_ack_c;
   assign busy       = (state_q != IDLE);
   assign data_valid = (state_q == BURST);
   assign data_out   = data_valid ? rd_data : 16'h0000;
   assign data_addr  = data_valid ? beat_byte_addr(base_q, beat_q) : 16'h0000;

endmodule

// File: tb/tb_mem_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_responder
//   Directed bench for mem_fill_responder: one default (LATENCY=4) instance
//   and one LATENCY=2 instance. Inputs change and outputs are sampled 1 ns
//   after the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_fill_responder;

   logic        clk;
   logic        rst;
   logic        fill_req;
   logic [15:0] fill_addr;
   logic        fill_ack;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic        busy;
   logic [15:0] data_out;
   logic        data_valid;
   logic [15:0] data_addr;

   logic        l2_fill_req;
   logic [15:0] l2_fill_addr;
   logic        l2_fill_ack;
   logic        l2_wr_en;
   logic [15:0] l2_wr_addr;
   logic [15:0] l2_wr_data;
   logic        l2_wr_ack;
   logic        l2_busy;
   logic [15:0] l2_data_out;
   logic        l2_data_valid;
   logic [15:0] l2_data_addr;

   int checks = 0;
   int errors = 0;

   logic [15:0] cap_d [8];
   logic [15:0] cap_a [8];
   int          cap_lat;
   int          cap_n;
   bit          cap_stray;

   mem_fill_responder dut (
      .clk        (clk),
      .rst        (rst),
      .fill_req   (fill_req),
      .fill_addr  (fill_addr),
      .fill_ack   (fill_ack),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .busy       (busy),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_addr  (data_addr)
   );

   mem_fill_responder #(.LATENCY(2)) dut_l2 (
      .clk        (clk),
      .rst        (rst),
      .fill_req   (l2_fill_req),
      .fill_addr  (l2_fill_addr),
      .fill_ack   (l2_fill_ack),
      .wr_en      (l2_wr_en),
      .wr_addr    (l2_wr_addr),
      .wr_data    (l2_wr_data),
      .wr_ack     (l2_wr_ack),
      .busy       (l2_busy),
      .data_out   (l2_data_out),
      .data_valid (l2_data_valid),
      .data_addr  (l2_data_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Single store in IDLE; wr_en is dropped just after the committing edge.
   task automatic write_word(input logic [15:0] a, input logic [15:0] d);
      int n;
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      #1;
      n = 0;
      while (wr_ack !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (wr_ack !== 1'b1) begin errors++; $display("FAIL prefill_wr_ack addr %h: got %b expected 1", a, wr_ack); end
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Called right after the fill_ack sample; collects up to 8 beats.
   task automatic capture_burst(input bit keep_req, input logic [15:0] next_addr);
      cap_lat = 0; cap_n = 0; cap_stray = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (keep_req) fill_addr = next_addr;
         else fill_req = 1'b0;
         #1;
         if (fill_ack === 1'b1 || wr_ack === 1'b1) cap_stray = 1'b1;
         if (data_valid === 1'b1) begin
            if (cap_n == 0) cap_lat = c + 1;
            cap_d[cap_n] = data_out;
            cap_a[cap_n] = data_addr;
            cap_n++;
            if (cap_n == 8) break;
         end else if (cap_n > 0) begin
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; wr_en = 1'b1; wr_addr = 16'h7FFE; wr_data = 16'h5A5A;
      fill_req = 1'b1; fill_addr = 16'h1230;
      #1;
      checks++; if (fill_ack !== 1'b0) begin errors++; $display("FAIL reset_fill_ack: got %b expected 0", fill_ack); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack: got %b expected 0", wr_ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
      checks++; if (data_addr !== 16'h0000) begin errors++; $display("FAIL reset_data_addr: got %h expected 0000", data_addr); end
      @(negedge clk);
      wr_en = 1'b0; fill_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic_fill();
      logic [15:0] exp_d [8];
      logic [15:0] ea;
      bit          ev;
      for (int k = 0; k < 8; k++) begin
         write_word(16'h0400 + 16'(2 * k), 16'h1000 + 16'(k));
         exp_d[k] = 16'h1000 + 16'(k);
      end
      exp_d[1] = 16'hBEEF;
      // cycle 0: store
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 16'h0402; wr_data = 16'hBEEF; fill_req = 1'b0;
      #1;
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL basic_wr_ack_c0: got %b expected 1", wr_ack); end
      checks++; if (fill_ack !== 1'b0) begin errors++; $display("FAIL basic_fill_ack_c0: got %b expected 0", fill_ack); end
      // cycle 1: fill
      @(negedge clk);
      wr_en = 1'b0; fill_req = 1'b1; fill_addr = 16'h040A;
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL basic_fill_ack_c1: got %b expected 1", fill_ack); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL basic_wr_ack_c1: got %b expected 0", wr_ack); end
      for (int i = 2; i <= 13; i++) begin
         @(negedge clk);
         fill_req = 1'b0;
         #1;
         ev = (i >= 5 && i <= 12);
         checks++; if (data_valid !== ev) begin errors++; $display("FAIL basic_valid_c%0d: got %b expected %b", i, data_valid, ev); end
         checks++; if (busy !== (i <= 12)) begin errors++; $display("FAIL basic_busy_c%0d: got %b expected %b", i, busy, (i <= 12)); end
         if (ev) begin
            ea = 16'h0400 + 16'(2 * (i - 5));
            checks++; if (data_addr !== ea) begin errors++; $display("FAIL basic_addr_c%0d: got %h expected %h", i, data_addr, ea); end
            checks++; if (data_out !== exp_d[i-5]) begin errors++; $display("FAIL basic_data_c%0d: got %h expected %h", i, data_out, exp_d[i-5]); end
         end else begin
            checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL basic_idle_data_c%0d: got %h expected 0000", i, data_out); end
         end
      end
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 16'h2236; wr_data = 16'hA5A5;
      fill_req = 1'b1; fill_addr = 16'h2230;
      #1;
      checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL same_wr_ack: got %b expected 1", wr_ack); end
      checks++; if (fill_ack !== 1'b0) begin errors++; $display("FAIL same_fill_ack_first: got %b expected 0", fill_ack); end
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL same_fill_ack_next: got %b expected 1", fill_ack); end
      checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL same_wr_ack_next: got %b expected 0", wr_ack); end
      capture_burst(1'b0, 16'h0000);
      checks++; if (cap_n !== 8) begin errors++; $display("FAIL same_beats: got %0d expected 8", cap_n); end
      checks++; if (cap_lat !== 4) begin errors++; $display("FAIL same_latency: got %0d expected 4", cap_lat); end
      checks++; if (cap_d[3] !== 16'hA5A5) begin errors++; $display("FAIL same_new_data: got %h expected a5a5", cap_d[3]); end
      checks++; if (cap_a[0] !== 16'h2230) begin errors++; $display("FAIL same_addr0: got %h expected 2230", cap_a[0]); end
      checks++; if (cap_a[7] !== 16'h223E) begin errors++; $display("FAIL same_addr7: got %h expected 223e", cap_a[7]); end
   endtask

   task automatic test_wr_during_burst();
      int nb, last_c, ack_c, bad;
      for (int k = 0; k < 8; k++) write_word(16'h3000 + 16'(2 * k), 16'h3000 + 16'(k));
      @(negedge clk);
      fill_req = 1'b1; fill_addr = 16'h3000;
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL wrburst_fill_ack: got %b expected 1", fill_ack); end
      nb = 0; last_c = -1; ack_c = -1; bad = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         fill_req = 1'b0; wr_en = 1'b1; wr_addr = 16'h3004; wr_data = 16'hDEAD;
         #1;
         if (data_valid === 1'b1) begin
            if (data_out !== 16'h3000 + 16'(nb)) bad++;
            nb++; last_c = c;
         end
         if (wr_ack === 1'b1) begin ack_c = c; break; end
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      checks++; if (nb !== 8) begin errors++; $display("FAIL wrburst_beats: got %0d expected 8", nb); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL wrburst_data_changed: got %0d bad beats expected 0", bad); end
      checks++; if (ack_c !== 12) begin errors++; $display("FAIL wrburst_ack_cycle: got %0d expected 12", ack_c); end
      checks++; if (ack_c !== last_c + 1) begin errors++; $display("FAIL wrburst_ack_after_last: got %0d expected %0d", ack_c, last_c + 1); end
      @(negedge clk);
      fill_req = 1'b1; fill_addr = 16'h3000;
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL wrburst_refill_ack: got %b expected 1", fill_ack); end
      capture_burst(1'b0, 16'h0000);
      checks++; if (cap_d[2] !== 16'hDEAD) begin errors++; $display("FAIL wrburst_late_store: got %h expected dead", cap_d[2]); end
      checks++; if (cap_d[3] !== 16'h3003) begin errors++; $display("FAIL wrburst_neighbour: got %h expected 3003", cap_d[3]); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      fill_req = 1'b1; fill_addr = 16'h0000;
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b expected 1", fill_ack); end
      capture_burst(1'b1, 16'hFFF0);
      checks++; if (cap_n !== 8) begin errors++; $display("FAIL b2b_beats1: got %0d expected 8", cap_n); end
      checks++; if (cap_stray !== 1'b0) begin errors++; $display("FAIL b2b_ack_mid_fill: got %b expected 0", cap_stray); end
      checks++; if (cap_a[0] !== 16'h0000) begin errors++; $display("FAIL b2b_addr1_first: got %h expected 0000", cap_a[0]); end
      checks++; if (cap_a[7] !== 16'h000E) begin errors++; $display("FAIL b2b_addr1_last: got %h expected 000e", cap_a[7]); end
      @(negedge clk);
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2_no_gap: got %b expected 1", fill_ack); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_gap: got %b expected 0", data_valid); end
      capture_burst(1'b0, 16'h0000);
      checks++; if (cap_n !== 8) begin errors++; $display("FAIL b2b_beats2: got %0d expected 8", cap_n); end
      checks++; if (cap_lat !== 4) begin errors++; $display("FAIL b2b_latency2: got %0d expected 4", cap_lat); end
      checks++; if (cap_a[0] !== 16'hFFF0) begin errors++; $display("FAIL b2b_addr2_first: got %h expected fff0", cap_a[0]); end
      checks++; if (cap_a[7] !== 16'hFFFE) begin errors++; $display("FAIL b2b_addr2_last: got %h expected fffe", cap_a[7]); end
   endtask

   task automatic test_reset_mid_burst();
      int nb, bad;
      for (int k = 0; k < 8; k++) write_word(16'h5550 + 16'(2 * k), 16'hC000 + 16'(k));
      @(negedge clk);
      fill_req = 1'b1; fill_addr = 16'h5550;
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL rstmid_fill_ack: got %b expected 1", fill_ack); end
      nb = 0;
      for (int c = 1; c <= 30 && nb < 4; c++) begin
         @(negedge clk);
         fill_req = 1'b0;
         #1;
         if (data_valid === 1'b1) nb++;
      end
      checks++; if (nb !== 4) begin errors++; $display("FAIL rstmid_reach_beat3: got %0d beats expected 4", nb); end
      rst = 1'b1;
      #1;
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", data_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rstmid_data_out: got %h expected 0000", data_out); end
      checks++; if (data_addr !== 16'h0000) begin errors++; $display("FAIL rstmid_data_addr: got %h expected 0000", data_addr); end
      @(negedge clk);
      #1;
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_held: got %b expected 0", data_valid); end
      @(negedge clk);
      rst = 1'b0; fill_req = 1'b1; fill_addr = 16'h5558;
      #1;
      checks++; if (fill_ack !== 1'b1) begin errors++; $display("FAIL rstmid_first_accept: got %b expected 1", fill_ack); end
      capture_burst(1'b0, 16'h0000);
      bad = 0;
      for (int k = 0; k < 8; k++) if (cap_d[k] !== 16'hC000 + 16'(k)) bad++;
      checks++; if (cap_n !== 8) begin errors++; $display("FAIL rstmid_refill_beats: got %0d expected 8", cap_n); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_store_intact: got %0d bad words expected 0", bad); end
      checks++; if (cap_a[0] !== 16'h5550) begin errors++; $display("FAIL rstmid_refill_addr: got %h expected 5550", cap_a[0]); end
   endtask

   task automatic test_latency2();
      int nb, lat;
      logic [15:0] d3, a0;
      logic        busy_seen;
      @(negedge clk);
      l2_wr_en = 1'b1; l2_wr_addr = 16'h0106; l2_wr_data = 16'h1234;
      #1;
      checks++; if (l2_wr_ack !== 1'b1) begin errors++; $display("FAIL lat2_wr_ack: got %b expected 1", l2_wr_ack); end
      @(negedge clk);
      l2_wr_en = 1'b0; l2_fill_req = 1'b1; l2_fill_addr = 16'h0100;
      #1;
      checks++; if (l2_fill_ack !== 1'b1) begin errors++; $display("FAIL lat2_fill_ack: got %b expected 1", l2_fill_ack); end
      nb = 0; lat = -1; d3 = 16'h0000; a0 = 16'h0000; busy_seen = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         l2_fill_req = 1'b0;
         #1;
         if (c == 1) busy_seen = l2_busy;
         if (l2_data_valid === 1'b1) begin
            if (nb == 0) begin lat = c; a0 = l2_data_addr; end
            if (nb == 3) d3 = l2_data_out;
            nb++;
         end else if (nb > 0) begin
            break;
         end
      end
      checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL lat2_busy: got %b expected 1", busy_seen); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL lat2_latency: got %0d expected 2", lat); end
      checks++; if (nb !== 8) begin errors++; $display("FAIL lat2_beats: got %0d expected 8", nb); end
      checks++; if (a0 !== 16'h0100) begin errors++; $display("FAIL lat2_addr0: got %h expected 0100", a0); end
      checks++; if (d3 !== 16'h1234) begin errors++; $display("FAIL lat2_data3: got %h expected 1234", d3); end
   endtask

   initial begin
      rst = 1'b1;
      fill_req = 1'b0; fill_addr = 16'h0000;
      wr_en = 1'b0; wr_addr = 16'h0000; wr_data = 16'h0000;
      l2_fill_req = 1'b0; l2_fill_addr = 16'h0000;
      l2_wr_en = 1'b0; l2_wr_addr = 16'h0000; l2_wr_data = 16'h0000;
      repeat (2) @(negedge clk);

      test_reset();
      test_basic_fill();
      test_same_cycle();
      test_wr_during_burst();
      test_back_to_back();
      test_reset_mid_burst();
      test_latency2();

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
